// File: rtl/sequence_detector.sv
// sequence_detector: samples a 3-bit symbol once per SAMPLE_DIV clocks and pulses on the
// 8-symbol pattern 001,101,110,000,110,110,011,101. Optional match counter: SEQ_DET_MATCH_COUNT_EN.
//
//   state | meaning
//   S0    | no pattern symbols matched
//   S1-S6 | first k pattern symbols matched
//   S7    | seven matched, waiting for final 101
module sequence_detector #(
    parameter int SAMPLE_DIV   = 10,
    parameter int SAMPLE_PHASE = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] data,
`ifdef SEQ_DET_MATCH_COUNT_EN
    output logic [7:0] match_count,
`endif
    output logic       sequence_found
);

    localparam int          CW      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [23:0] PATTERN = 24'h370D9D;
    localparam logic [2:0]  SYM_RESTART = 3'b001;

    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_t;

    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q;
    logic          found_q;
    logic          sample_strobe;
    logic [2:0]    expected_sym;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SAMPLE_DIV - 1)) begin
            cnt_d = '0;
        end
    end

    assign sample_strobe = (cnt_q == CW'(SAMPLE_PHASE));

    // First symbol lives in the MSBs, so state k indexes from the top.
    always_comb begin
        expected_sym = PATTERN[23 - 3*int'(state_q) -: 3];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S0;
            found_q <= 1'b0;
        end else begin
            found_q <= 1'b0;
            if (sample_strobe) begin
                if (data == expected_sym) begin
                    if (state_q == S7) begin
                        state_q <= S0;
                        found_q <= 1'b1;
                    end else begin
                        state_q <= state_t'(state_q + 3'd1);
                    end
                end else if (data == SYM_RESTART) begin
                    // 001 only starts the pattern, so it is the only useful fallback.
                    state_q <= S1;
                end else begin
                    state_q <= S0;
                end
            end
        end
    end

    assign sequence_found = found_q;

`ifdef SEQ_DET_MATCH_COUNT_EN
    logic [7:0] match_count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            match_count_q <= 8'd0;
        end else if (sample_strobe && (state_q == S7) && (data == expected_sym)
                     && (match_count_q != 8'hFF)) begin
            match_count_q <= match_count_q + 8'd1;
        end
    end

    assign match_count = match_count_q;
`endif

endmodule

// File: tb/tb_sequence_detector.sv
// Bench for sequence_detector: directed and random symbol streams checked every clock against
// a sliding-window model of the last eight sampled symbols.
module tb_sequence_detector;

    localparam int DIV = 10;
    localparam int PH  = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] data  = 3'b000;
    logic       sequence_found;
`ifdef SEQ_DET_MATCH_COUNT_EN
    logic [7:0] match_count;
`endif

    sequence_detector #(.SAMPLE_DIV(DIV), .SAMPLE_PHASE(PH)) dut (
        .clock          (clock),
        .reset          (reset),
        .data           (data),
`ifdef SEQ_DET_MATCH_COUNT_EN
        .match_count    (match_count),
`endif
        .sequence_found (sequence_found)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tick_no = 0;
    int pulses = 0;
    int first_pulse_t = -1;
    int last_pulse_t = -1;
    int exp_count = 0;
    logic [2:0] hist[$];
    logic [2:0] pat [8] = '{3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011, 3'b101};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model from the values present at the edge, then compare.
    task automatic tick();
        logic exp_found;
        logic win_match;
        exp_found = 1'b0;
        @(posedge clock);
        tick_no++;
        if (!reset) begin
            cyc = 0;
            hist.delete();
            exp_count = 0;
        end else begin
            if (cyc == PH) begin
                hist.push_back(data);
                if (hist.size() > 8) void'(hist.pop_front());
                win_match = (hist.size() == 8);
                for (int i = 0; i < hist.size(); i++)
                    if (hist[i] != pat[i]) win_match = 1'b0;
                if (win_match) begin
                    exp_found = 1'b1;
                    if (exp_count < 255) exp_count++;
                end
            end
            cyc = (cyc + 1) % DIV;
        end
        #1;
        check("sequence_found", sequence_found, exp_found);
`ifdef SEQ_DET_MATCH_COUNT_EN
        check("match_count", match_count, exp_count);
`endif
        if (sequence_found === 1'b1) begin
            pulses++;
            if (first_pulse_t < 0) first_pulse_t = tick_no;
            last_pulse_t = tick_no;
        end
    endtask

    task automatic send(input logic [2:0] sym);
        data = sym;
        repeat (DIV) tick();
    endtask

    task automatic send_pat();
        for (int i = 0; i < 8; i++) send(pat[i]);
    endtask

    task automatic clear_pulses();
        pulses = 0;
        first_pulse_t = -1;
        last_pulse_t = -1;
    endtask

    int t_start;

    initial begin
        // 1: long reset, then release
        reset = 1'b0;
        data  = 3'b000;
        repeat (10) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("t1_no_pulse", pulses, 0);
        // realign so each symbol starts at divider count 0
        reset = 1'b0; tick(); reset = 1'b1;

        // 2: single pattern, pulse one clock after the final strobe
        clear_pulses();
        t_start = tick_no;
        send_pat();
        check("t2_pulses", pulses, 1);
        check("t2_latency", first_pulse_t - t_start, 7*DIV + PH + 1);

        // 3: non-matching stream
        clear_pulses();
        send(3'b000); send(3'b001); send(3'b010); send(3'b011);
        check("t3_pulses", pulses, 0);

        // 4: partial pattern broken by 010
        send(3'b001); send(3'b101); send(3'b010); send(3'b011);
        check("t4_pulses", pulses, 0);

        // 5: back-to-back patterns, then one pattern with a trailing tail
        reset = 1'b0; tick(); reset = 1'b1;
        clear_pulses();
        send_pat();
        send_pat();
        check("t5_pulses", pulses, 2);
        check("t5_gap", last_pulse_t - first_pulse_t, 8*DIV);
        clear_pulses();
        send_pat();
        send(3'b010); send(3'b110); send(3'b011); send(3'b101);
        check("t5b_pulses", pulses, 1);

        // 6: reset while in S6 discards progress
        reset = 1'b0; tick(); reset = 1'b1;
        clear_pulses();
        for (int i = 0; i < 6; i++) send(pat[i]);
        reset = 1'b0; tick(); reset = 1'b1;
        send(3'b011); send(3'b101);
        check("t6_no_pulse", pulses, 0);
        send_pat();
        check("t6_pulse", pulses, 1);

        // random streams mixing full patterns, prefixes and noise
        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 2))
                0: send_pat();
                1: begin
                    for (int i = 0; i < int'($urandom_range(1, 7)); i++) send(pat[i]);
                end
                default: begin
                    for (int i = 0; i < 4; i++) send(3'($urandom_range(0, 7)));
                end
            endcase
        end

`ifdef SEQ_DET_MATCH_COUNT_EN
        // drive the counter into saturation
        reset = 1'b0; tick(); reset = 1'b1;
        repeat (258) send_pat();
        check("count_saturated", match_count, 255);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sequence_detector.md
Name: sequence_detector

Overview:
- Serial pattern matcher on a 3-bit symbol stream.
- Samples `data` once per symbol period and pulses `sequence_found` when the fixed 8-symbol pattern 001,101,110,000,110,110,011,101 has been received in consecutive symbol periods.
- Overlapping detection.
- Sits after a slow symbol source whose symbols are held for SAMPLE_DIV clocks each.

Parameters:
- SAMPLE_DIV, default 10: clocks per symbol period; integer ≥ 1. With 1, every clock samples.
- SAMPLE_PHASE, default 5: counter value at which `data` is sampled; 0 ≤ SAMPLE_PHASE < SAMPLE_DIV. Mid-period sampling avoids symbol edges.

Ports:
- clock, input, 1: single system clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
- data, input, 3: current input symbol.
- sequence_found, output, 1: one-clock pulse on pattern completion.
- match_count, output, 8: present only with SEQ_DET_MATCH_COUNT_EN.

Behaviour:
- Reset (reset=0, asynchronous):
  - div counter = 0, FSM = S0, sequence_found = 0, match_count = 0.
  - Reset mid-pattern discards all partial progress.
- Divider:
  - Counter runs 0..SAMPLE_DIV-1 and wraps; it starts at 0 on the first clock after reset release.
  - sample_strobe = (counter == SAMPLE_PHASE).
  - Identical consecutive symbols count as separate symbols (one per period), so 110,110 matches pattern positions 5 and 6.
- Pattern P[0..7] = 001,101,110,000,110,110,011,101, stored as a fixed 24-bit constant 0x370D9D, first symbol in the MSBs.
- FSM states: S0..S7, where Sk = first k pattern symbols matched. State changes only on sample_strobe; it holds otherwise.
- Transition in Sk on strobe:
  - data == P[k] and k < 7: go to Sk+1.
  - data == P[7] in S7: full match; go to S0 and assert match.
  - Any other mismatch: go to S1 if data == 001, else S0. 001 occurs only at pattern position 0, so no longer fallback exists.
- Overlap: after a full match, a following 001 advances S0→S1, so back-to-back patterns are each detected.
- sequence_found:
  - Registered; set to 1 on the clock edge at which the 8th symbol is accepted.
  - High for exactly one clock cycle, then 0, regardless of SAMPLE_DIV.
  - Latency: rises 1 clock after the sampling edge of the final symbol.
- X/illegal states: FSM encoding uses 3 bits; all 8 codes are legal, so there are no unreachable states.
- sequence_found is never high while reset=0.

Optional Feature:
- Macro SEQ_DET_MATCH_COUNT_EN.
- Defined:
  - Adds output match_count[7:0].
  - Increments in the same cycle sequence_found pulses.
  - Saturates at 255 (no wrap).
  - Cleared by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset held low for 10 clocks with data=000, then released → sequence_found=0 throughout; FSM in S0.
2. Full pattern, one symbol per 10 clocks (001,101,110,000,110,110,011,101) → exactly one 1-clock pulse, 1 clock after the strobe sampling 101; match_count=1 if enabled.
3. Non-matching stream 000,001,010,011 → no pulse.
4. Partial pattern 001,101,010,011 → no pulse; FSM returns to S0 after 010.
5. Pattern sent twice back-to-back (16 symbols) → two pulses exactly 8 symbol periods (80 clocks) apart; then 001,101,110,000,110,110,011,101,010,110,011,101 → one pulse, none for the trailing 4 symbols.
6. Assert reset for 1 clock while in S6, then send the last two symbols 011,101 → no pulse; the full pattern afterwards → pulse.
